// File: rtl/imm_decode_stage_pkg.sv
// Shared formats, RV opcodes and skid-buffer depth for the immediate decode stage.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_U    = 3'd1,
      FMT_S    = 3'd2,
      FMT_R    = 3'd3,
      FMT_B    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_OP32     = 7'b0111011;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bundle for the decode stage: instruction in, decoded entry out.
interface imm_decode_stage_if
   import imm_pkg::*;
#(
   parameter int XLEN = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   fmt_e             out_fmt;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_target;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_illegal
   );
endinterface

// File: rtl/imm_decode_stage_decode.sv
// Combinational RV format/immediate decode. IMM_ZICSR_EN: SYSTEM with funct3[2]=1
// decodes as Z (zero-extended uimm in rs1 field); otherwise all SYSTEM is I.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            illegal
);
   // Every immediate is first built as a signed 32-bit value, then widened by a signed cast.
   logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};

   always_comb begin
      fmt     = FMT_NONE;
      imm     = '0;
      illegal = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_OP_IMM, OP_OP_IMM32, OP_JALR: begin
            fmt = FMT_I;
            imm = XLEN'(imm_i);
         end
         OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
            if (instr[14]) begin
               fmt = FMT_Z;
               imm = XLEN'(instr[19:15]);
            end else begin
               fmt = FMT_I;
               imm = XLEN'(imm_i);
            end
`else
            fmt = FMT_I;
            imm = XLEN'(imm_i);
`endif
         end
         OP_STORE: begin
            fmt = FMT_S;
            imm = XLEN'(imm_s);
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            imm = XLEN'(imm_b);
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            imm = XLEN'(imm_u);
         end
         OP_JAL: begin
            fmt = FMT_J;
            imm = XLEN'(imm_j);
         end
         OP_OP, OP_OP32: fmt = FMT_R;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode behind a 2-entry skid FIFO; 1-cycle latency, in_ready
// driven only by occupancy. IMM_ZICSR_EN enables the Z (CSR uimm) format.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int TARGET_EN = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   imm_decode_stage_if.slave   bus
);
   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
      fmt_e            fmt;
      logic            illegal;
   } entry_t;

   entry_t          mem [FIFO_DEPTH];
   entry_t          head;
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] dec_target;
   fmt_e            dec_fmt;
   logic            dec_illegal;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (bus.in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   generate
      if (TARGET_EN != 0) begin : g_target
         assign dec_target = (dec_fmt == FMT_B || dec_fmt == FMT_J) ? bus.in_pc + dec_imm : '0;
      end else begin : g_no_target
         assign dec_target = '0;
      end
   endgenerate

   assign bus.in_ready  = (count < 2'(FIFO_DEPTH));
   assign bus.out_valid = (count != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push && !reset && !flush) begin
         mem[wr_ptr] <= '{imm: dec_imm, pc: bus.in_pc, target: dec_target,
                          fmt: dec_fmt, illegal: dec_illegal};
      end
   end

   assign head            = mem[rd_ptr];
   assign bus.out_imm     = bus.out_valid ? head.imm    : '0;
   assign bus.out_pc      = bus.out_valid ? head.pc     : '0;
   assign bus.out_target  = bus.out_valid ? head.target : '0;
   assign bus.out_fmt     = bus.out_valid ? head.fmt    : FMT_NONE;
   assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage (XLEN=64): decode vector table plus FIFO corner sequences.
module tb_imm_decode_stage;
   import imm_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   n_cmp = 0;
   int   n_err = 0;

   imm_decode_stage_if #(.XLEN(64)) bus ();

   imm_decode_stage #(.XLEN(64), .TARGET_EN(1)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [63:0] tgt;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive_push(input logic [31:0] instr, input logic [63:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".valid"},   64'(bus.out_valid),   64'd0);
      chk({name, ".imm"},     bus.out_imm,          64'd0);
      chk({name, ".fmt"},     64'(bus.out_fmt),     64'd7);
      chk({name, ".illegal"}, 64'(bus.out_illegal), 64'd0);
      chk({name, ".target"},  bus.out_target,       64'd0);
      chk({name, ".pc"},      bus.out_pc,           64'd0);
   endtask

   initial begin
      // Decode vectors: instr, pc, imm, fmt, illegal, target
      vecs[0]  = '{32'hFFF00093, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 64'h0};
      vecs[1]  = '{32'hFE000EE3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0, 64'hFFC};
      vecs[2]  = '{32'h800000B7, 64'h40,   64'hFFFF_FFFF_8000_0000, 3'd1, 1'b0, 64'h0};
`ifdef IMM_ZICSR_EN
      vecs[3]  = '{32'h300FD073, 64'h44,   64'd31,                  3'd6, 1'b0, 64'h0};
`else
      vecs[3]  = '{32'h300FD073, 64'h44,   64'h300,                 3'd0, 1'b0, 64'h0};
`endif
      vecs[4]  = '{32'h0000007F, 64'h48,   64'h0,                   3'd7, 1'b1, 64'h0};
      vecs[5]  = '{32'hFE20AC23, 64'h4C,   64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 64'h0};
      vecs[6]  = '{32'h001000EF, 64'h2000, 64'h800,                 3'd5, 1'b0, 64'h2800};
      vecs[7]  = '{32'h002081B3, 64'h50,   64'h0,                   3'd3, 1'b0, 64'h0};
      vecs[8]  = '{32'h12345297, 64'h54,   64'h1234_5000,           3'd1, 1'b0, 64'h0};
      vecs[9]  = '{32'h00412083, 64'h58,   64'h4,                   3'd0, 1'b0, 64'h0};
      vecs[10] = '{32'hFFDFF06F, 64'h10,   64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0, 64'hC};
      vecs[11] = '{32'hFFFFF0E7, 64'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 64'h0};

      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 64'h0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      // Reset with an entry offered: it must not survive.
      drive_push(32'h00100093, 64'h0);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk_idle("reset");
      chk("reset.in_ready", 64'(bus.in_ready), 64'd1);

      // Table-driven decode, one entry at a time.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive_push(vecs[i].instr, vecs[i].pc);
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk($sformatf("v%0d.valid", i),   64'(bus.out_valid),   64'd1);
         chk($sformatf("v%0d.imm", i),     bus.out_imm,          vecs[i].imm);
         chk($sformatf("v%0d.fmt", i),     64'(bus.out_fmt),     64'(vecs[i].fmt));
         chk($sformatf("v%0d.illegal", i), 64'(bus.out_illegal), 64'(vecs[i].ill));
         chk($sformatf("v%0d.target", i),  bus.out_target,       vecs[i].tgt);
         chk($sformatf("v%0d.pc", i),      bus.out_pc,           vecs[i].pc);
      end
      @(negedge clk);
      chk_idle("drained");

      // Backpressure: three back-to-back pushes, only two fit.
      bus.out_ready = 1'b0;
      drive_push(32'h00100093, 64'hA0);
      @(negedge clk);
      chk("bp.ready1", 64'(bus.in_ready), 64'd1);
      drive_push(32'h00200093, 64'hA4);
      @(negedge clk);
      drive_push(32'h00300093, 64'hA8);
      chk("bp.ready_full", 64'(bus.in_ready), 64'd0);
      chk("bp.hold_imm", bus.out_imm, 64'd1);
      @(negedge clk);
      chk("bp.still_full", 64'(bus.in_ready), 64'd0);
      chk("bp.hold_pc", bus.out_pc, 64'hA0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp.drain0", bus.out_imm, 64'd1);
      @(negedge clk);
      chk("bp.drain1", bus.out_imm, 64'd2);
      chk("bp.drain1_pc", bus.out_pc, 64'hA4);
      @(negedge clk);
      chk_idle("bp.empty");

      // Simultaneous push and pop at count=1 keeps order and occupancy.
      drive_push(32'h00500093, 64'hB0);
      @(negedge clk);
      drive_push(32'h00600093, 64'hB4);
      chk("pp.head0", bus.out_imm, 64'd5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("pp.head1", bus.out_imm, 64'd6);
      chk("pp.ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      chk("pp.empty", 64'(bus.out_valid), 64'd0);

      // Flush at count=2 with a push offered.
      bus.out_ready = 1'b0;
      drive_push(32'h00700093, 64'hC0);
      @(negedge clk);
      drive_push(32'h00800093, 64'hC4);
      @(negedge clk);
      drive_push(32'h00900093, 64'hC8);
      flush = 1'b1;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk_idle("flush2");
      chk("flush2.ready", 64'(bus.in_ready), 64'd1);

      // Flush at count=1: the push that fits must still be dropped.
      drive_push(32'h00A00093, 64'hD0);
      @(negedge clk);
      drive_push(32'h00B00093, 64'hD4);
      flush = 1'b1;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush1.valid", 64'(bus.out_valid), 64'd0);
      // Pointers wrapped through several cycles; a fresh entry must still land at the head.
      drive_push(32'h00C00093, 64'hE0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("post_flush.imm", bus.out_imm, 64'd12);
      chk("post_flush.pc", bus.out_pc, 64'hE0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TARGET_EN, default 1; when 1, out_target is computed, otherwise it is tied to 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-008 SHALL have port in_instr  input  32  raw RV instruction.
REQ-009 SHALL have port in_pc  input  XLEN  instruction address.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-013 SHALL have port out_fmt  output  3  format code per REQ-016.
REQ-014 SHALL have port out_pc, out_target  output  XLEN  pass-through PC; pc+imm for B/J.
REQ-015 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-016 Format codes SHALL be: I=0, U=1, S=2, R=3, B=4, J=5, Z=6, NONE=7.
REQ-017 Format SHALL be derived from opcode[6:0]: 0000011/0010011/0011011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011/0111011 -> R; anything else -> NONE, with out_illegal=1.
REQ-018 Immediates SHALL be sign-extended from instr[31] to XLEN: I 12-bit; S 12-bit; B 13-bit with LSB 0; J 21-bit with LSB 0; U = instr[31:12]<<12, sign-extended; R/NONE = 0.
REQ-019 out_target SHALL equal out_pc+out_imm modulo 2^XLEN for B and J, and 0 for all other formats.
REQ-020 Decode SHALL be registered with 1-cycle latency: an entry accepted in cycle N is visible on out_* from cycle N+1 when the buffer was empty.
REQ-021 The stage SHALL contain a 2-entry FIFO (skid buffer); in_ready = (count<2) and depends only on registered state.
REQ-022 A transfer SHALL occur on valid&&ready at each port; outputs SHALL hold stable while out_valid&&!out_ready.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve order; a push at count=2 SHALL be impossible.
REQ-024 When out_valid=0, out_imm/out_target/out_pc SHALL be 0, out_fmt SHALL be NONE and out_illegal SHALL be 0.
REQ-025 flush SHALL set count to 0 at the next edge; a same-cycle push SHALL be dropped; flush SHALL have priority over push and pop.
REQ-026 Wrap-around of the read and write pointers (1 bit each) SHALL be seamless.

Reset
REQ-027 reset SHALL clear count and both pointers, giving out_valid=0 and in_ready=1 from the following cycle.
REQ-028 reset SHALL take priority over flush and handshakes; an entry in flight at reset SHALL be lost.

Configuration
REQ-029 With IMM_ZICSR_EN defined, opcode 1110011 with funct3[2]=1 SHALL decode as Z, with imm = zero-extended instr[19:15].
REQ-030 Without IMM_ZICSR_EN, all 1110011 instructions SHALL decode as I, and code 6 SHALL never appear.

Structure
REQ-031 Package imm_pkg SHALL hold the fmt_e enum (REQ-016), the opcode constants and the FIFO depth constant 2.
REQ-032 Combinational decode SHALL live in sub-module imm_decode (parameter XLEN), instantiated once ahead of the FIFO write.

Verification
REQ-033 XLEN=64, in 0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFF_FFFF_FFFF_FFFF, fmt=I.
REQ-034 in 0xFE000EE3 (beq -4), pc=0x1000 -> out_imm=-4, fmt=B, out_target=0xFFC.
REQ-035 XLEN=64, in 0x800000B7 (lui) -> out_imm=0xFFFF_FFFF_8000_0000; XLEN=32 -> 0x8000_0000.
REQ-036 out_ready=0, three back-to-back pushes -> two accepted, in_ready=0 on the third; release -> in-order drain.
REQ-037 flush while count=2 and in_valid=1 -> next cycle out_valid=0, count=0, pushed entry lost.
REQ-038 in 0x300FD073 (csrrwi) -> with IMM_ZICSR_EN imm=31, fmt=Z; without it imm=0x300, fmt=I; opcode 0x7F -> illegal=1, imm=0.
